fetch_unit: RTL
===============

# fetch_unit

Instruction fetch and program-counter stage for the single-cycle 32-bit MIPS-style core. It owns the PC and issues word fetches to instruction memory over a req/ack handshake. It holds the fetched instruction while it executes and presents the decode fields (opcode, funct, rt0) to the control unit. At commit it computes the next PC from the control unit's branch and jump selects.

## Interface
Parameters:
- RESET_VECTOR, 32'h0040_0000, PC loaded on reset and on jump select 11.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request, valid in FETCH.
- imem_addr  out  32  fetch address, equals pc.
- imem_ack  in  1  instruction memory has returned imem_rdata (same-cycle ack allowed).
- imem_rdata  in  32  fetched instruction word.
- stall  in  1  datapath hold; blocks commit in EXEC.
- branch_sel  in  1  0 sequential, 1 branch taken.
- jump_sel  in  2  00 seq/branch, 01 J target, 10 jump register, 11 reset vector.
- branch_offset  in  32  sign-extended immediate, in words.
- jump_reg  in  32  rs register value.
- instr  out  32  held instruction.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- rt0  out  1  instr[16].
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc+4, used as the link value.
- instr_valid  out  1  high in EXEC.
- instr_commit  out  1  instr_valid && !stall; the datapath gates all register and memory writes with it.
- align_err  out  1  sticky misaligned jump-register flag.
- instr_count  out  32  committed-instruction counter.

## Operation
- FSM states: RST, FETCH, EXEC.
- RST:
  - Entered on reset and lasts one cycle.
  - Loads pc to RESET_VECTOR, then moves to FETCH.
- FETCH:
  - Drives imem_req=1 with imem_addr=pc.
  - On imem_ack, latches imem_rdata into instr and moves to EXEC.
  - Without ack, stays in FETCH with pc stable.
- EXEC:
  - Drives instr_valid=1.
  - While stall=1: holds state; pc and instr are unchanged.
  - When stall=0: commits, updates pc to next_pc and moves to FETCH.
- next_pc selection:
  - jump_sel 00, branch_sel 0: pc+4.
  - jump_sel 00, branch_sel 1: pc+4+(branch_offset<<2), modulo 2^32.
  - jump_sel 01: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - jump_sel 10: {jump_reg[31:2], 2'b00}. If jump_reg[1:0]≠0, also set align_err.
  - jump_sel 11: RESET_VECTOR.
- Select signals, offset and jump_reg are sampled only on the commit cycle. X or unknown selects in any other state are ignored.
- instr_count increments on every instr_commit and wraps from 32'hFFFF_FFFF to 0.
- align_err clears only on reset.
- imem_ack outside FETCH is ignored.

## Timing
Reset values, taking effect in the cycle after reset is sampled high:
- state = RST, pc = RESET_VECTOR.
- instr = 32'h0000_0000 (NOP), so opcode = 0, funct = 0, rt0 = 0.
- imem_req = 0, instr_valid = 0, instr_commit = 0.
- align_err = 0, instr_count = 0.
- pc_plus4 = RESET_VECTOR+4.

Latency and rules:
- Minimum throughput is 2 cycles per instruction: FETCH with same-cycle ack, then EXEC with stall=0.
- Each cycle of ack delay or of stall adds one cycle.
- instr and the decode fields are registered. They change only on the FETCH→EXEC edge.
- pc changes only on the commit edge or in RST.
- Reset in any state (mid-fetch, mid-stall) wins:
  - Next cycle is RST; imem_req drops.
  - A pending ack is discarded; no commit occurs and instr_count does not increment.
- imem_req stays asserted continuously in FETCH. imem_addr is stable until ack.

## Structure
- Shared package (core_pkg):
  - FSM state encoding.
  - JUMP_SEQ/JUMP_TGT/JUMP_REG/JUMP_RST encodings for jump_sel; these must match the control unit's encoding.
  - Instruction field bit positions (opcode, funct, rt0, target).
  - Default reset vector constant.
- One combinational sub-module, next_pc_calc:
  - Inputs: pc, instr[25:0], branch_sel, jump_sel, branch_offset, jump_reg.
  - Outputs: next_pc, misalign.
- FSM, registers and counter live in fetch_unit.

## Test plan
- Reset then ack tied high, memory word at 0x00400000 = 32'h2010_0005 → imem_addr=0x00400000 on the first FETCH cycle.
  - Next cycle: opcode=6'b001000, instr_valid=1.
  - Next fetch addr 0x00400004; 2 cycles per instruction; instr_count=1 after the first commit.
- Ack delayed 3 cycles → imem_req held 4 cycles with the address stable.
  - Exactly one commit; ack pulses arriving during EXEC are ignored.
- Branch at pc=0x00400010, branch_sel=1, offset=-2 → next pc 0x0040000C.
  - Same instruction with offset 32'h0000_0003 → next pc 0x00400020.
- Jumps:
  - jump_sel=01 with instr[25:0]=26'h0100008 at pc=0x00400000 → next pc 0x00400020.
  - jump_sel=10 with jump_reg=0x00400033 → next pc 0x00400030, align_err=1 and sticky.
- stall held 5 cycles in EXEC → instr_commit low for 5 cycles, pc/instr unchanged, instr_count does not increment.
  - Release → a single commit.
- Reset asserted mid-FETCH and mid-stall → next cycle state RST, imem_req=0, pc=RESET_VECTOR, instr_count=0, align_err=0.
  - Preload the counter to 32'hFFFF_FFFF (force), then commit → count wraps to 0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared encodings and constants for the fetch stage and control unit.
// Contents: FSM state encoding, jump_sel encodings (shared with the control
// unit), instruction field positions and the default reset vector.
package core_pkg;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        JUMP_SEQ = 2'b00,
        JUMP_TGT = 2'b01,
        JUMP_REG = 2'b10,
        JUMP_RST = 2'b11
    } jump_sel_t;

    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W   = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int FUNCT_W    = 6;
    localparam int RT0_BIT    = 16;
    localparam int TARGET_W   = 26;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0040_0000;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational next-PC selection for the fetch stage.
// Ports:
//   pc            in  32  address of the executing instruction
//   target        in  26  instr[25:0] J-type target field
//   branch_sel    in  1   branch taken (only with jump_sel == JUMP_SEQ)
//   jump_sel      in  2   JUMP_SEQ / JUMP_TGT / JUMP_REG / JUMP_RST
//   branch_offset in  32  sign-extended word offset
//   jump_reg      in  32  rs register value
//   next_pc       out 32  selected next PC
//   misalign      out 1   jump-register target had nonzero low bits
module next_pc_calc
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic [31:0]         pc,
    input  logic [TARGET_W-1:0] target,
    input  logic                branch_sel,
    input  logic [1:0]          jump_sel,
    input  logic [31:0]         branch_offset,
    input  logic [31:0]         jump_reg,
    output logic [31:0]         next_pc,
    output logic                misalign
);

    logic [31:0] seq_pc;

    assign seq_pc = pc + 32'd4;

    always_comb begin
        next_pc  = seq_pc;
        misalign = 1'b0;
        case (jump_sel)
            JUMP_SEQ: next_pc = branch_sel ? seq_pc + {branch_offset[29:0], 2'b00} : seq_pc;
            JUMP_TGT: next_pc = {seq_pc[31:28], target, 2'b00};
            JUMP_REG: begin
                next_pc  = {jump_reg[31:2], 2'b00};
                misalign = |jump_reg[1:0];
            end
            default:  next_pc = RESET_VECTOR;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction fetch stage with req/ack imem handshake.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   imem_req/imem_addr             fetch request and address (== pc) in FETCH
//   imem_ack/imem_rdata            memory response, honoured only in FETCH
//   stall                          holds the instruction in EXEC
//   branch_sel/jump_sel            next-PC selects, sampled on commit only
//   branch_offset/jump_reg         branch word offset, jump-register value
//   instr/opcode/funct/rt0         held instruction and its decode fields
//   pc/pc_plus4                    held instruction address and link value
//   instr_valid/instr_commit       EXEC indicator and write-enable for datapath
//   align_err                      sticky misaligned jump-register flag
//   instr_count                    committed-instruction counter (wraps)
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_sel,
    input  logic [1:0]  jump_sel,
    input  logic [31:0] branch_offset,
    input  logic [31:0] jump_reg,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        rt0,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        instr_commit,
    output logic        align_err,
    output logic [31:0] instr_count
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        align_err_q, align_err_d;
    logic [31:0] next_pc;
    logic        misalign;

    next_pc_calc #(.RESET_VECTOR(RESET_VECTOR)) u_next_pc (
        .pc            (pc_q),
        .target        (instr_q[TARGET_W-1:0]),
        .branch_sel    (branch_sel),
        .jump_sel      (jump_sel),
        .branch_offset (branch_offset),
        .jump_reg      (jump_reg),
        .next_pc       (next_pc),
        .misalign      (misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RST;
            pc_q          <= RESET_VECTOR;
            instr_q       <= '0;
            instr_count_q <= '0;
            align_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_count_q <= instr_count_d;
            align_err_q   <= align_err_d;
        end
    end

    // Selects only matter through instr_commit, so unknown selects outside
    // the commit cycle cannot disturb pc, align_err or the counter.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_count_d = instr_count_q + {31'd0, instr_commit};
        align_err_d   = align_err_q | (instr_commit & misalign);
        case (state_q)
            ST_RST: begin
                pc_d    = RESET_VECTOR;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_RST;
        endcase
    end

    assign imem_req     = (state_q == ST_FETCH);
    assign imem_addr    = pc_q;
    assign instr_valid  = (state_q == ST_EXEC);
    assign instr_commit = instr_valid & ~stall;
    assign instr        = instr_q;
    assign opcode       = instr_q[OPCODE_LSB +: OPCODE_W];
    assign funct        = instr_q[FUNCT_LSB +: FUNCT_W];
    assign rt0          = instr_q[RT0_BIT];
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + 32'd4;
    assign align_err    = align_err_q;
    assign instr_count  = instr_count_q;

endmodule
